// File: rtl/xyolo_write_ctrl.sv
// Sequencer for the YOLO write stage: walks the vread pixel memory, strobes the
// xyolo load controls and emits vwrite writes, with optional 2x2 max-pool grouping.
module xyolo_write_ctrl #(
    parameter int MEM_ADDR_W    = 11,
    parameter int VWRITE_ADDR_W = 10,
    parameter int CNT_W         = 16,
    parameter int RES_LAT       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    output logic                     done,
    input  logic [CNT_W-1:0]         n_macs,
    input  logic [CNT_W-1:0]         n_out,
    input  logic [MEM_ADDR_W-1:0]    rd_start,
    input  logic [MEM_ADDR_W-1:0]    rd_incr,
    input  logic [MEM_ADDR_W-1:0]    rd_out_incr,
    input  logic [VWRITE_ADDR_W-1:0] wr_start,
    input  logic                     maxpool,
    output logic                     vread_enB,
    output logic [MEM_ADDR_W-1:0]    vread_addrB,
    output logic                     vwrite_enB,
    output logic [VWRITE_ADDR_W-1:0] vwrite_addrB,
    output logic                     ld_acc,
    output logic                     ld_mp,
    output logic                     ld_res
);

    localparam logic [CNT_W-1:0]         CNT_ONE = 1;
    localparam logic [VWRITE_ADDR_W-1:0] WR_ONE  = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]         cfg_last_k, cfg_last_o;
    logic [MEM_ADDR_W-1:0]    cfg_rd_incr, cfg_rd_out_incr;
    logic                     cfg_maxpool;
    logic [CNT_W-1:0]         k, o;
    logic [MEM_ADDR_W-1:0]    rd_addr, base_addr, base_next;
    logic [VWRITE_ADDR_W-1:0] wr_addr;
    // Bit 0 of each pipe is aligned with ld_res; the top bit is the write cycle.
    logic [RES_LAT:0]         res_sr, wr_sr;

    logic issue, accept, last_k, last_o, pending;

    assign issue     = (state == ISSUE);
    assign accept    = (state == IDLE) && run && (n_macs != '0) && (n_out != '0);
    assign last_k    = (k == cfg_last_k);
    assign last_o    = (o == cfg_last_o);
    assign base_next = base_addr + cfg_rd_out_incr;
    assign pending   = |res_sr[RES_LAT-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (last_k && last_o) state_next = DRAIN;
            DRAIN:   if (!pending) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_last_k      <= '0;
            cfg_last_o      <= '0;
            cfg_rd_incr     <= '0;
            cfg_rd_out_incr <= '0;
            cfg_maxpool     <= 1'b0;
            k               <= '0;
            o               <= '0;
            rd_addr         <= '0;
            base_addr       <= '0;
            wr_addr         <= '0;
            res_sr          <= '0;
            wr_sr           <= '0;
            ld_acc          <= 1'b0;
            ld_mp           <= 1'b0;
        end else begin
            res_sr <= {res_sr[RES_LAT-1:0], issue && last_k};
            // Only the last member of a pool group (o mod 4 == 3) produces a write.
            wr_sr  <= {wr_sr[RES_LAT-1:0],
                       issue && last_k && (!cfg_maxpool || o[1:0] == 2'd3)};
            ld_acc <= issue && (k == '0);
            ld_mp  <= issue && last_k && cfg_maxpool && (o[1:0] != 2'd0);

            if (wr_sr[RES_LAT]) wr_addr <= wr_addr + WR_ONE;

            if (accept) begin
                cfg_last_k      <= n_macs - CNT_ONE;
                cfg_last_o      <= n_out - CNT_ONE;
                cfg_rd_incr     <= rd_incr;
                cfg_rd_out_incr <= rd_out_incr;
                cfg_maxpool     <= maxpool;
                k               <= '0;
                o               <= '0;
                rd_addr         <= rd_start;
                base_addr       <= rd_start;
                wr_addr         <= wr_start;
            end else if (issue) begin
                if (last_k) begin
                    k         <= '0;
                    o         <= o + CNT_ONE;
                    base_addr <= base_next;
                    rd_addr   <= base_next;
                end else begin
                    k       <= k + CNT_ONE;
                    rd_addr <= rd_addr + cfg_rd_incr;
                end
            end
        end
    end

    assign done         = (state == IDLE);
    assign vread_enB    = issue;
    assign vread_addrB  = issue ? rd_addr : '0;
    assign ld_res       = res_sr[0];
    assign vwrite_enB   = wr_sr[RES_LAT];
    assign vwrite_addrB = wr_sr[RES_LAT] ? wr_addr : '0;

endmodule

// File: tb/tb_xyolo_write_ctrl.sv
// Directed bench for xyolo_write_ctrl: logs every strobe relative to the run
// cycle and compares against hand-computed schedules.
module tb_xyolo_write_ctrl;

    localparam int MEM_ADDR_W    = 11;
    localparam int VWRITE_ADDR_W = 10;
    localparam int CNT_W         = 16;
    localparam int RES_LAT       = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     run = 1'b0;
    logic                     done;
    logic [CNT_W-1:0]         n_macs = '0;
    logic [CNT_W-1:0]         n_out = '0;
    logic [MEM_ADDR_W-1:0]    rd_start = '0;
    logic [MEM_ADDR_W-1:0]    rd_incr = '0;
    logic [MEM_ADDR_W-1:0]    rd_out_incr = '0;
    logic [VWRITE_ADDR_W-1:0] wr_start = '0;
    logic                     maxpool = 1'b0;
    logic                     vread_enB;
    logic [MEM_ADDR_W-1:0]    vread_addrB;
    logic                     vwrite_enB;
    logic [VWRITE_ADDR_W-1:0] vwrite_addrB;
    logic                     ld_acc, ld_mp, ld_res;

    xyolo_write_ctrl #(
        .MEM_ADDR_W(MEM_ADDR_W), .VWRITE_ADDR_W(VWRITE_ADDR_W),
        .CNT_W(CNT_W), .RES_LAT(RES_LAT)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .done(done),
        .n_macs(n_macs), .n_out(n_out), .rd_start(rd_start), .rd_incr(rd_incr),
        .rd_out_incr(rd_out_incr), .wr_start(wr_start), .maxpool(maxpool),
        .vread_enB(vread_enB), .vread_addrB(vread_addrB),
        .vwrite_enB(vwrite_enB), .vwrite_addrB(vwrite_addrB),
        .ld_acc(ld_acc), .ld_mp(ld_mp), .ld_res(ld_res)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start   = 0;

    int rd_c[$], rd_a[$], acc_c[$], res_c[$], mp_v[$], wr_c[$], wr_a[$];
    int done_rise = -1;
    bit done_low  = 1'b0;
    bit prev_done = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (vread_enB) begin
                rd_c.push_back(cyc - start);
                rd_a.push_back(int'(vread_addrB));
            end
            if (ld_acc) acc_c.push_back(cyc - start);
            if (ld_res) begin
                res_c.push_back(cyc - start);
                mp_v.push_back(int'(ld_mp));
            end
            if (vwrite_enB) begin
                wr_c.push_back(cyc - start);
                wr_a.push_back(int'(vwrite_addrB));
            end
            if (done && !prev_done && done_rise < 0) done_rise = cyc - start;
            if (!done) done_low = 1'b1;
        end
        prev_done = done;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic clear_logs();
        rd_c.delete(); rd_a.delete(); acc_c.delete(); res_c.delete();
        mp_v.delete(); wr_c.delete(); wr_a.delete();
        done_rise = -1;
        done_low  = 1'b0;
    endtask

    // Called just after a posedge; that cycle becomes cycle 0 of the job.
    task automatic start_job(input int nm, input int no, input int rs, input int ri,
                             input int roi, input int ws, input bit mp, input bit busy);
        n_macs      = CNT_W'(nm);
        n_out       = CNT_W'(no);
        rd_start    = MEM_ADDR_W'(rs);
        rd_incr     = MEM_ADDR_W'(ri);
        rd_out_incr = MEM_ADDR_W'(roi);
        wr_start    = VWRITE_ADDR_W'(ws);
        maxpool     = mp;
        clear_logs();
        start = cyc;
        run   = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        // Scramble the inputs: the job must use the latched copy.
        n_macs = 16'd7; n_out = 16'd9; rd_start = 11'd100; rd_incr = 11'd3;
        rd_out_incr = 11'd50; wr_start = 10'd300; maxpool = ~mp;
        if (busy) begin
            repeat (2) @(posedge clk);
            #1 run = 1'b1;
            @(posedge clk);
            #1 run = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400 && done_rise < 0; i++) @(posedge clk);
        check({tag, "_finished"}, int'(done_rise >= 0), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int e_c[$], e_a[$];

    initial begin
        #12;
        check("rst_done", int'(done), 1);
        check("rst_outs", int'({vread_enB, vwrite_enB, ld_acc, ld_mp, ld_res}), 0);
        check("rst_addr", int'(vread_addrB) + int'(vwrite_addrB), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic job
        start_job(3, 2, 0, 1, 3, 5, 1'b0, 1'b0);
        wait_done("basic");
        e_c = '{1, 2, 3, 4, 5, 6};   check_q("basic_rd_cyc", rd_c, e_c);
        e_a = '{0, 1, 2, 3, 4, 5};   check_q("basic_rd_addr", rd_a, e_a);
        e_c = '{2, 5};               check_q("basic_acc", acc_c, e_c);
        e_c = '{4, 7};               check_q("basic_res", res_c, e_c);
        e_c = '{6, 9};               check_q("basic_wr_cyc", wr_c, e_c);
        e_a = '{5, 6};               check_q("basic_wr_addr", wr_a, e_a);
        check("basic_done_rise", done_rise, 10);

        // Strided base step, vwrite address wrap
        start_job(2, 3, 10, 2, 5, 1023, 1'b0, 1'b0);
        wait_done("stride");
        e_a = '{10, 12, 15, 17, 20, 22}; check_q("stride_rd_addr", rd_a, e_a);
        e_c = '{2, 4, 6};                check_q("stride_acc", acc_c, e_c);
        e_c = '{3, 5, 7};                check_q("stride_res", res_c, e_c);
        e_c = '{5, 7, 9};                check_q("stride_wr_cyc", wr_c, e_c);
        e_a = '{1023, 0, 1};             check_q("stride_wr_addr", wr_a, e_a);
        check("stride_done_rise", done_rise, 10);

        // Max-pool, n_macs=1
        start_job(1, 8, 0, 1, 1, 0, 1'b1, 1'b0);
        wait_done("mp");
        e_c = '{2, 3, 4, 5, 6, 7, 8, 9}; check_q("mp_acc", acc_c, e_c);
        check_q("mp_res", res_c, e_c);
        e_a = '{0, 1, 1, 1, 0, 1, 1, 1}; check_q("mp_ldmp", mp_v, e_a);
        e_c = '{7, 11};                  check_q("mp_wr_cyc", wr_c, e_c);
        e_a = '{0, 1};                   check_q("mp_wr_addr", wr_a, e_a);
        check("mp_done_rise", done_rise, 12);

        // Partial pool group and read address wrap
        start_job(1, 6, 2046, 1, 1, 7, 1'b1, 1'b0);
        wait_done("part");
        e_a = '{2046, 2047, 0, 1, 2, 3}; check_q("part_rd_addr", rd_a, e_a);
        e_a = '{0, 1, 1, 1, 0, 1};       check_q("part_ldmp", mp_v, e_a);
        e_c = '{7};                      check_q("part_wr_cyc", wr_c, e_c);
        e_a = '{7};                      check_q("part_wr_addr", wr_a, e_a);
        check("part_done_rise", done_rise, 10);
        if (res_c.size() > 0)
            check("part_done_after_res", done_rise - res_c[res_c.size()-1], 3);

        // Zero-length runs
        start_job(0, 5, 0, 1, 1, 0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("zero_macs_reads", rd_c.size(), 0);
        check("zero_macs_strobes", acc_c.size() + res_c.size() + wr_c.size(), 0);
        check("zero_macs_done_low", int'(done_low), 0);
        start_job(4, 0, 0, 1, 1, 0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("zero_out_reads", rd_c.size(), 0);
        check("zero_out_done_low", int'(done_low), 0);

        // Second run while busy
        start_job(3, 2, 0, 1, 3, 5, 1'b0, 1'b1);
        wait_done("busy");
        check("busy_reads", rd_c.size(), 6);
        e_a = '{5, 6};  check_q("busy_wr_addr", wr_a, e_a);
        check("busy_done_rise", done_rise, 10);

        // Reset during ISSUE
        start_job(3, 4, 0, 1, 3, 5, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_active", int'(vread_enB), 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_done", int'(done), 1);
        check("midrst_outs", int'({vread_enB, vwrite_enB, ld_acc, ld_mp, ld_res}), 0);
        check("midrst_addr", int'(vread_addrB) + int'(vwrite_addrB), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_writes", wr_c.size(), 0);
        check("midrst_no_reads", rd_c.size(), 0);
        start_job(3, 2, 0, 1, 3, 5, 1'b0, 1'b0);
        wait_done("after_rst");
        e_a = '{0, 1, 2, 3, 4, 5};  check_q("after_rst_rd_addr", rd_a, e_a);
        e_c = '{6, 9};              check_q("after_rst_wr_cyc", wr_c, e_c);
        e_a = '{5, 6};              check_q("after_rst_wr_addr", wr_a, e_a);
        check("after_rst_done_rise", done_rise, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xyolo_write_ctrl.md
# xyolo_write_ctrl

Sequencer for the YOLO write stage: after a `run` pulse it drives the internal-side read port of the vread pixel memory, the load-control strobes of the xyolo vector, and the internal-side write port of the vwrite memories. Together these carry out `n_out` accumulations of `n_macs` pixel×weight products each, with optional 2×2 max-pool grouping. It sits beside the write stage and is configured per layer by the Versat control registers. External-side transfers (ext addrgens, merge) are not its concern.

## Interface
- `MEM_ADDR_W`, 11: vread memory address width.
- `VWRITE_ADDR_W`, 10: vwrite memory address width.
- `CNT_W`, 16: width of the loop counters `n_macs` and `n_out`.
- `RES_LAT`, 2: cycles from `ld_res` to valid xyolo `flow_out`; minimum 1.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `run` in 1: start pulse; sampled only in IDLE.
- `done` out 1: high when idle and no job is pending.
- `n_macs` in CNT_W: products per accumulation.
- `n_out` in CNT_W: number of accumulations.
- `rd_start` in MEM_ADDR_W: vread address of the first product.
- `rd_incr` in MEM_ADDR_W: address step between products.
- `rd_out_incr` in MEM_ADDR_W: base step between accumulations.
- `wr_start` in VWRITE_ADDR_W: first vwrite address.
- `maxpool` in 1: group 4 accumulations per written result.
- `vread_enB` out 1, `vread_addrB` out MEM_ADDR_W: vread read port.
- `vwrite_enB` out 1, `vwrite_addrB` out VWRITE_ADDR_W: vwrite write port.
- `ld_acc`, `ld_mp`, `ld_res` out 1 each: xyolo load controls.

## Operation
- States are IDLE, ISSUE and DRAIN.
- Configuration is latched on the accepted `run`. Inputs may change afterwards without effect.
- **IDLE to ISSUE:** on `run` when `n_macs`≠0 and `n_out`≠0.
- **Zero-length run:** if `n_macs`=0 or `n_out`=0, `run` is a no-op. No strobes are issued and `done` stays 1.
- **ISSUE:**
  - One read per cycle. Counters are k (0..n_macs-1, inner loop) and o (0..n_out-1, outer loop).
  - Read address = base + k·`rd_incr`, with base = `rd_start` + o·`rd_out_incr`. Computed incrementally, wrapping modulo 2^MEM_ADDR_W.
  - After the last read (k=n_macs-1, o=n_out-1), go to DRAIN.
- **Strobes:** each registered one cycle after the read that caused it, so they are aligned with the pixel on the read port.
  - `ld_acc` = (k==0).
  - `ld_res` = (k==n_macs-1).
  - `ld_mp` = `ld_res` & maxpool & (p≠0), where p = o mod 4 is the pool position. At p=0 the pool register is loaded; at p=1..3 it is compared with the stored max.
- **Writes:** `vwrite_enB` pulses `RES_LAT` cycles after a qualifying `ld_res` (delay line).
  - With `maxpool`=0, every `ld_res` qualifies.
  - With `maxpool`=1, only p=3 qualifies.
  - `vwrite_addrB` starts at `wr_start` and increments after each write, wrapping modulo 2^VWRITE_ADDR_W.
  - With `maxpool`=1, a trailing partial group (n_out mod 4 ≠ 0) is computed but never written.
- **DRAIN:** wait until the delay line is empty, then go to IDLE and raise `done`.
- `run` during ISSUE or DRAIN is ignored.
- **n_macs=1:** `ld_acc` and `ld_res` are both high on every pixel cycle.
- **Reset (also mid-job):** state goes to IDLE, the delay line and counters clear, all strobes and addresses go to 0, and `done`=1. No partial write is emitted after `rst` deasserts.

## Timing
- Reset values: `done`=1. All other outputs are 0.
- Take `run` high at cycle 0:
  - `done` falls at cycle 1.
  - The first `vread_enB` is at cycle 1.
  - Reads run at cycles 1..n_macs·n_out, back-to-back with no bubbles between accumulations.
- Strobes lag their read by exactly 1 cycle. `vwrite_enB` lags its `ld_res` by exactly `RES_LAT` cycles.
- `done` rises the cycle after the last `vwrite_enB`.
- With `maxpool`=1 and no write at the tail, `done` rises at last `ld_res` + `RES_LAT` + 1.
- A new `run` is accepted in the same cycle that `done` is first high.

## Test plan
- **Basic job.** Config: n_macs=3, n_out=2, rd_start=0, rd_incr=1, rd_out_incr=3, wr_start=5, RES_LAT=2, run at cycle 0. Required:
  - reads at addresses 0..5 on cycles 1..6;
  - `ld_acc` at cycles 2 and 5;
  - `ld_res` at cycles 4 and 7;
  - `vwrite_enB` at cycle 6 (addr 5) and cycle 9 (addr 6);
  - `done` rises at cycle 10.
- **Max-pool.** Config: n_macs=1, n_out=8, maxpool=1, wr_start=0. Required:
  - `ld_mp` on the 8 `ld_res` cycles = 0,1,1,1,0,1,1,1;
  - exactly 2 writes, to addresses 0 and 1.
- **Partial group and wrap.** Config: maxpool=1, n_out=6, rd_start=2046 (MEM_ADDR_W=11), rd_incr=1. Required:
  - read addresses wrap 2046, 2047, 0, ...;
  - exactly 1 write;
  - `done` rises at last `ld_res` + 3.
- **Zero-length and busy run.** `run` with n_macs=0 -> no strobes and `done` stays 1. A second `run` pulse mid-job -> ignored; the read count still equals n_macs·n_out.
- **Reset mid-job.** `rst` asserted during ISSUE -> all outputs are 0 and `done`=1 in the same cycle (asynchronous). After release there are no further `vwrite_enB` pulses, and a new `run` executes a full job correctly.
